// File: rtl/cfu_arb2.sv
// rtl/cfu_arb2.sv - two-requester round-robin arbiter sharing one in-order CFU
// Optional counters under CFU_ARB2_STATS_EN (grant_cnt0/1, full_stall_cnt).
module cfu_arb2 #(
    parameter int CFU_FUNCTION_ID_W = 1,
    parameter int CFU_REQ_RESP_ID_W = 6,
    parameter int CFU_REQ_DATA_W    = 32,
    parameter int CFU_RESP_DATA_W   = 32,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [2*CFU_FUNCTION_ID_W-1:0] req_func,
    input  logic [2*CFU_REQ_RESP_ID_W-1:0] req_id,
    input  logic [2*CFU_REQ_DATA_W-1:0]    req_data0,
    input  logic [2*CFU_REQ_DATA_W-1:0]    req_data1,
    output logic [1:0]                     resp_valid,
    input  logic [1:0]                     resp_ready,
    output logic [CFU_REQ_RESP_ID_W-1:0]   resp_id,
    output logic [CFU_RESP_DATA_W-1:0]     resp_data,
    output logic                           resp_status,
    output logic                           cfu_req_valid,
    input  logic                           cfu_req_ready,
    output logic [CFU_FUNCTION_ID_W-1:0]   cfu_req_func,
    output logic [CFU_REQ_RESP_ID_W-1:0]   cfu_req_id,
    output logic [CFU_REQ_DATA_W-1:0]      cfu_req_data0,
    output logic [CFU_REQ_DATA_W-1:0]      cfu_req_data1,
    input  logic                           cfu_resp_valid,
    output logic                           cfu_resp_ready,
    input  logic [CFU_REQ_RESP_ID_W-1:0]   cfu_resp_id,
    input  logic [CFU_RESP_DATA_W-1:0]     cfu_resp_data,
    input  logic                           cfu_resp_status,
`ifdef CFU_ARB2_STATS_EN
    output logic [31:0]                    grant_cnt0,
    output logic [31:0]                    grant_cnt1,
    output logic [31:0]                    full_stall_cnt,
`endif
    output logic                           err
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    logic          r_rr;
    logic          r_lock;
    logic          r_lock_src;
    logic          r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic w_gnt;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // A stalled request keeps its source so the downstream fields stay stable.
    always_comb begin
        w_gnt = r_rr;
        if (r_lock) begin
            w_gnt = r_lock_src;
        end else if (req_valid == 2'b01) begin
            w_gnt = 1'b0;
        end else if (req_valid == 2'b10) begin
            w_gnt = 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted so they clear immediately.
    assign cfu_req_valid = rst & req_valid[w_gnt] & ~w_full;
    assign cfu_req_func  = w_gnt ? req_func[2*CFU_FUNCTION_ID_W-1:CFU_FUNCTION_ID_W]
                                 : req_func[CFU_FUNCTION_ID_W-1:0];
    assign cfu_req_id    = w_gnt ? req_id[2*CFU_REQ_RESP_ID_W-1:CFU_REQ_RESP_ID_W]
                                 : req_id[CFU_REQ_RESP_ID_W-1:0];
    assign cfu_req_data0 = w_gnt ? req_data0[2*CFU_REQ_DATA_W-1:CFU_REQ_DATA_W]
                                 : req_data0[CFU_REQ_DATA_W-1:0];
    assign cfu_req_data1 = w_gnt ? req_data1[2*CFU_REQ_DATA_W-1:CFU_REQ_DATA_W]
                                 : req_data1[CFU_REQ_DATA_W-1:0];

    assign req_ready[0] = rst & ~w_gnt & cfu_req_ready & ~w_full;
    assign req_ready[1] = rst &  w_gnt & cfu_req_ready & ~w_full;

    assign resp_valid[0]  = rst & cfu_resp_valid & ~w_empty & ~w_head;
    assign resp_valid[1]  = rst & cfu_resp_valid & ~w_empty &  w_head;
    assign cfu_resp_ready = rst & ~w_empty & resp_ready[w_head];
    assign resp_id        = cfu_resp_id;
    assign resp_data      = cfu_resp_data;
    assign resp_status    = cfu_resp_status;
    assign err            = r_err;

    assign w_push = cfu_req_valid & cfu_req_ready;
    assign w_pop  = cfu_resp_valid & cfu_resp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr       <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_src <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_lock   <= 1'b0;
                r_rr     <= ~w_gnt;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else if (cfu_req_valid) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_gnt;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (cfu_resp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Routing storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_gnt;
        end
    end

`ifdef CFU_ARB2_STATS_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_full_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_cnt0     <= '0;
            r_grant_cnt1     <= '0;
            r_full_stall_cnt <= '0;
        end else begin
            if (w_push && !w_gnt) begin
                r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_push && w_gnt) begin
                r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            end
            if (w_full && (req_valid != 2'b00)) begin
                r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt0     = r_grant_cnt0;
    assign grant_cnt1     = r_grant_cnt1;
    assign full_stall_cnt = r_full_stall_cnt;
`endif

endmodule

// File: tb/tb_cfu_arb2.sv
// tb/tb_cfu_arb2.sv - scoreboard bench for cfu_arb2 with an in-order multiply CFU model
module tb_cfu_arb2;
    localparam int FW = 1;
    localparam int IW = 6;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int MO = 4;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*FW-1:0] req_func;
    logic [2*IW-1:0] req_id;
    logic [2*DW-1:0] req_data0;
    logic [2*DW-1:0] req_data1;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready;
    logic [IW-1:0]   resp_id;
    logic [RW-1:0]   resp_data;
    logic            resp_status;
    logic            cfu_req_valid;
    logic            cfu_req_ready;
    logic [FW-1:0]   cfu_req_func;
    logic [IW-1:0]   cfu_req_id;
    logic [DW-1:0]   cfu_req_data0;
    logic [DW-1:0]   cfu_req_data1;
    logic            cfu_resp_valid;
    logic            cfu_resp_ready;
    logic [IW-1:0]   cfu_resp_id;
    logic [RW-1:0]   cfu_resp_data;
    logic            cfu_resp_status;
    logic            err;
`ifdef CFU_ARB2_STATS_EN
    logic [31:0]     grant_cnt0;
    logic [31:0]     grant_cnt1;
    logic [31:0]     full_stall_cnt;
`endif

    logic [FW-1:0] cur_fn [2];
    logic [IW-1:0] cur_id [2];
    logic [DW-1:0] cur_d0 [2];
    logic [DW-1:0] cur_d1 [2];

    assign req_func  = {cur_fn[1], cur_fn[0]};
    assign req_id    = {cur_id[1], cur_id[0]};
    assign req_data0 = {cur_d0[1], cur_d0[0]};
    assign req_data1 = {cur_d1[1], cur_d1[0]};

    cfu_arb2 #(
        .CFU_FUNCTION_ID_W(FW),
        .CFU_REQ_RESP_ID_W(IW),
        .CFU_REQ_DATA_W   (DW),
        .CFU_RESP_DATA_W  (RW),
        .MAX_OUTSTANDING  (MO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_func       (req_func),
        .req_id         (req_id),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_data      (resp_data),
        .resp_status    (resp_status),
        .cfu_req_valid  (cfu_req_valid),
        .cfu_req_ready  (cfu_req_ready),
        .cfu_req_func   (cfu_req_func),
        .cfu_req_id     (cfu_req_id),
        .cfu_req_data0  (cfu_req_data0),
        .cfu_req_data1  (cfu_req_data1),
        .cfu_resp_valid (cfu_resp_valid),
        .cfu_resp_ready (cfu_resp_ready),
        .cfu_resp_id    (cfu_resp_id),
        .cfu_resp_data  (cfu_resp_data),
        .cfu_resp_status(cfu_resp_status),
`ifdef CFU_ARB2_STATS_EN
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .full_stall_cnt (full_stall_cnt),
`endif
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          src;
        logic [IW-1:0] id;
        logic [RW-1:0] data;
    } exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [RW-1:0] data;
    } cfu_t;

    exp_t sb [$];
    cfu_t mq [$];
    logic gl [$];
    logic [1:0] acc;
    int  n_acc;
    int  exp_stall;
    bit  resp_en;
    bit  bad_pulse;

    // Scoreboard, grant log and downstream CFU model, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cfu_t c;
        acc = 2'b00;
        if (!rst) begin
            sb.delete();
            mq.delete();
            n_acc     = 0;
            exp_stall = 0;
        end else begin
            if (req_valid != 2'b00 && sb.size() == MO) exp_stall++;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc[i] = 1'b1;
                    e.src  = i[0];
                    e.id   = cur_id[i];
                    e.data = cur_d0[i] * cur_d1[i];
                    sb.push_back(e);
                    gl.push_back(i[0]);
                    n_acc++;
                end
            end
            if (resp_valid == 2'b11) check_eq("resp_onehot", resp_valid, 2'b01);
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (sb.size() == 0) begin
                        check_eq("resp_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("resp_src", i, e.src);
                        check_eq("resp_id", resp_id, e.id);
                        check_eq("resp_data", resp_data, e.data);
                    end
                end
            end
            if (cfu_req_valid && cfu_req_ready) begin
                c.id   = cfu_req_id;
                c.data = cfu_req_data0 * cfu_req_data1;
                mq.push_back(c);
            end
            if (cfu_resp_valid && cfu_resp_ready && mq.size() > 0) void'(mq.pop_front());
        end
    end

    always @(posedge clk) begin
        #2;
        cfu_resp_valid = rst && (bad_pulse || (resp_en && mq.size() > 0));
        if (mq.size() > 0) begin
            cfu_resp_id   = mq[0].id;
            cfu_resp_data = mq[0].data;
        end else begin
            cfu_resp_id   = '0;
            cfu_resp_data = '0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] id, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        cur_fn[i]    = 1'b1;
        cur_id[i]    = id;
        cur_d0[i]    = a;
        cur_d1[i]    = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_acc(input int i, input string tag);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!acc[i] && k < 20);
        check_eq(tag, acc[i], 1'b1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || mq.size() != 0) && k < 50) begin
            cyc();
            k++;
        end
        check_eq(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent [2];
        int g0;
        int k;
        rst             = 1'b0;
        req_valid       = 2'b00;
        resp_ready      = 2'b11;
        cfu_req_ready   = 1'b1;
        cfu_resp_valid  = 1'b0;
        cfu_resp_id     = '0;
        cfu_resp_data   = '0;
        cfu_resp_status = 1'b0;
        resp_en         = 1'b0;
        bad_pulse       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur_fn[i] = '0;
            cur_id[i] = '0;
            cur_d0[i] = '0;
            cur_d1[i] = '0;
        end
        #3;
        check_eq("rst_resp_valid", resp_valid, 2'b00);
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_cfu_req_valid", cfu_req_valid, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Single request from requester 0 to a multiplying CFU.
        resp_en = 1'b1;
        set_req(0, 6'd5, 32'd3, 32'd4);
        wait_acc(0, "t1_acc");
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) break;
        end
        check_eq("t1_resp_valid", resp_valid, 2'b01);
        check_eq("t1_resp_id", resp_id, 6'd5);
        check_eq("t1_resp_data", resp_data, 32'd12);
        cyc();
        wait_drain("t1_drain");

        // Both requesters busy: grants alternate, starting with 1 after the lone grant to 0.
        g0 = gl.size();
        sent[0] = 0;
        sent[1] = 0;
        set_req(0, 6'h00, $urandom_range(1, 1000), $urandom_range(1, 1000));
        set_req(1, 6'h20, $urandom_range(1, 1000), $urandom_range(1, 1000));
        k = 0;
        while ((sent[0] < 4 || sent[1] < 4) && k < 40) begin
            cyc();
            k++;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    sent[i]++;
                    if (sent[i] < 4)
                        set_req(i, {i[0], 5'(sent[i])}, $urandom_range(1, 1000), $urandom_range(1, 1000));
                    else
                        req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
        check_eq("t2_ngrant", gl.size() - g0, 8);
        if (gl.size() - g0 >= 8) begin
            for (int j = 0; j < 8; j++) check_eq("t2_grant_order", gl[g0+j], (j % 2 == 0) ? 1'b1 : 1'b0);
        end
        wait_drain("t2_drain");

        // Lone grant to 1 leaves priority with 0, so a stalled 1 must hold via the lock.
        set_req(1, 6'h31, 32'd2, 32'd3);
        wait_acc(1, "t3_pre_acc");
        wait_drain("t3_pre_drain");
        cfu_req_ready = 1'b0;
        set_req(1, 6'h2a, 32'd7, 32'd8);
        cyc();
        set_req(0, 6'h15, 32'd2, 32'd9);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq("t3_hold_id", cfu_req_id, 6'h2a);
            check_eq("t3_hold_data0", cfu_req_data0, 32'd7);
            check_eq("t3_hold_ready", req_ready, 2'b00);
            cyc();
        end
        cfu_req_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_release_ready", req_ready, 2'b10);
        cyc();
        check_eq("t3_acc1", acc[1], 1'b1);
        set_req(1, 6'h2b, 32'd5, 32'd5);
        @(negedge clk);
        check_eq("t3_next_id", cfu_req_id, 6'h15);
        check_eq("t3_next_ready", req_ready, 2'b01);
        cyc();
        check_eq("t3_acc0", acc[0], 1'b1);
        req_valid[0] = 1'b0;
        wait_acc(1, "t3_acc1b");
        wait_drain("t3_drain");

        // Order FIFO fills at MAX_OUTSTANDING; the fifth request waits for a pop.
        resp_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            set_req(0, 6'(j + 8), 32'(j + 1), 32'd10);
            wait_acc(0, "t4_acc");
        end
        set_req(0, 6'd12, 32'd6, 32'd6);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq("t4_full_ready", req_ready[0], 1'b0);
            check_eq("t4_full_cfu_valid", cfu_req_valid, 1'b0);
            cyc();
        end
        resp_en = 1'b1;
        wait_acc(0, "t4_acc5");
        wait_drain("t4_drain");
`ifdef CFU_ARB2_STATS_EN
        check_eq("t4_stall_cnt", full_stall_cnt, exp_stall);
        check_eq("t4_grant_sum", grant_cnt0 + grant_cnt1, n_acc);
`endif

        // Head owned by requester 0 blocks requester 1's response.
        resp_en = 1'b0;
        set_req(0, 6'h01, 32'd11, 32'd2);
        wait_acc(0, "t5_acc0");
        set_req(1, 6'h21, 32'd13, 32'd3);
        wait_acc(1, "t5_acc1");
        resp_ready = 2'b10;
        resp_en    = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check_eq("t5_block_cfu_ready", cfu_resp_ready, 1'b0);
            check_eq("t5_block_valid", resp_valid, 2'b01);
            cyc();
        end
        resp_ready = 2'b11;
        wait_drain("t5_drain");

        // Response with nothing outstanding is a sticky error.
        bad_pulse = 1'b1;
        @(negedge clk);
        check_eq("t6_bad_cfu_ready", cfu_resp_ready, 1'b0);
        check_eq("t6_bad_resp_valid", resp_valid, 2'b00);
        cyc();
        bad_pulse = 1'b0;
        check_eq("t6_err_set", err, 1'b1);
        cyc();
        cyc();
        cyc();
        check_eq("t6_err_sticky", err, 1'b1);

        // Asynchronous reset with an entry in flight.
        resp_en = 1'b0;
        set_req(0, 6'h33, 32'd4, 32'd4);
        wait_acc(0, "t6_acc_pre");
        set_req(1, 6'h34, 32'd4, 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_err", err, 1'b0);
        check_eq("t6_rst_resp_valid", resp_valid, 2'b00);
        check_eq("t6_rst_req_ready", req_ready, 2'b00);
        check_eq("t6_rst_cfu_req_valid", cfu_req_valid, 1'b0);
        check_eq("t6_rst_cfu_resp_ready", cfu_resp_ready, 1'b0);
        req_valid = 2'b00;
        cyc();
        cyc();
`ifdef CFU_ARB2_STATS_EN
        check_eq("t6_rst_grant0", grant_cnt0, 0);
        check_eq("t6_rst_stall", full_stall_cnt, 0);
`endif
        rst     = 1'b1;
        resp_en = 1'b1;
        cyc();
        set_req(1, 6'h11, 32'd3, 32'd3);
        wait_acc(1, "t6_post_acc");
        wait_drain("t6_post_drain");
        check_eq("t6_post_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
